// File: rtl/acl_poll_sched.sv
// acl_poll_sched: master-side ACL TX slot scheduler choosing LT_ADDR and
// packet kind (DATA / POLL / NULL-ACK) for each master TX slot pair.
//
// Ports:
//   clk_6M, rst          clock, async active-high reset
//   sched_en             scheduler enable (also gates Tpoll counting)
//   regi_isMaster        device is master; FSM inert when 0
//   link_active[7:0]     per-LT_ADDR link up (bit0 ignored)
//   txdat_ready[7:0]     per-link ACL payload queued
//   dec_flow[7:0]        last received FLOW per link (1 = GO)
//   arq_owed[7:0]        per-link ACK owed (used only with the macro below)
//   tpoll_wr/tpoll_wdata Tpoll register write (slot pairs, 0 = no polling)
//   sco_reserved         slot pair reserved for SCO/eSCO
//   ms_tslot_p           start of master TX slot pair
//   ms_TXslot_endp       end of TX slot
//   ms_RXslot_endp       end of RX slot
//   sched_valid/sched_lt_addr/sched_kind  held grant
//   sched_busy           FSM not IDLE
//   sched_overrun        slot pair started while not IDLE (1-cycle pulse)
//   tpoll_expired[7:0]   per-link Tpoll expired (bit0 always 0)
//
// Optional feature macro: SCHED_ARQ_PRIO_EN
//   defined   -> adds NULL-ACK class (kind 11), priority DATA > NULL-ACK > POLL
//   undefined -> arq_owed ignored, kind 11 never produced

module acl_poll_sched #(
    parameter int CNT_W     = 16,
    parameter int TPOLL_RST = 40
) (
    input  logic             clk_6M,
    input  logic             rst,
    input  logic             sched_en,
    input  logic             regi_isMaster,
    input  logic [7:0]       link_active,
    input  logic [7:0]       txdat_ready,
    input  logic [7:0]       dec_flow,
    input  logic [7:0]       arq_owed,
    input  logic             tpoll_wr,
    input  logic [CNT_W-1:0] tpoll_wdata,
    input  logic             sco_reserved,
    input  logic             ms_tslot_p,
    input  logic             ms_TXslot_endp,
    input  logic             ms_RXslot_endp,
    output logic             sched_valid,
    output logic [2:0]       sched_lt_addr,
    output logic [1:0]       sched_kind,
    output logic             sched_busy,
    output logic             sched_overrun,
    output logic [7:0]       tpoll_expired
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARB     = 2'd1,
        GRANT   = 2'd2,
        WAIT_RX = 2'd3
    } state_t;

    localparam logic [1:0] K_NONE = 2'b00;
    localparam logic [1:0] K_DATA = 2'b01;
    localparam logic [1:0] K_POLL = 2'b10;
    localparam logic [1:0] K_NACK = 2'b11;

    // LT_ADDR 0 is broadcast and never scheduled
    localparam logic [7:0]       LINK_MASK = 8'hFE;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t           state, state_nx;
    logic [2:0]       rr_ptr, rr_ptr_nx;
    logic [CNT_W-1:0] tpoll;

    logic             valid_nx;
    logic [2:0]       addr_nx;
    logic [1:0]       kind_nx;
    logic             overrun_nx;
    logic             grant_ld;
    logic             run;

    logic [7:0]       data_req, poll_req, owe_req;
    logic [3:0]       data_pick, poll_pick, owe_pick;
    logic             win_hit;
    logic [2:0]       win_addr;
    logic [1:0]       win_kind;

    assign run        = sched_en & regi_isMaster;
    assign sched_busy = (state != IDLE);

    // Round-robin over 1..7 starting after ptr; returns {hit, addr}.
    // Scanning backwards lets the earliest candidate in search order win.
    function automatic logic [3:0] rr_pick(input logic [7:0] req,
                                           input logic [2:0] ptr);
        logic [3:0] res;
        logic [2:0] idx;
        res = '0;
        for (int k = 6; k >= 0; k--) begin
            idx = 3'(((32'(ptr) + k) % 7) + 1);
            if (req[idx])
                res = {1'b1, idx};
        end
        return res;
    endfunction

    always_ff @(posedge clk_6M or posedge rst) begin
        if (rst)
            tpoll <= CNT_W'(TPOLL_RST);
        else if (tpoll_wr)
            tpoll <= tpoll_wdata;
    end

    // Per-link Tpoll aging counters, in slot pairs
    assign tpoll_expired[0] = 1'b0;

    for (genvar g = 1; g < 8; g++) begin : g_link
        logic [CNT_W-1:0] cnt;

        always_ff @(posedge clk_6M or posedge rst) begin
            if (rst)
                cnt <= '0;
            else if (!link_active[g] || (grant_ld && addr_nx == 3'(g)))
                cnt <= '0;
            else if (ms_tslot_p && sched_en && cnt != CNT_MAX)
                cnt <= cnt + CNT_W'(1);
        end

        assign tpoll_expired[g] = (tpoll != '0) && (cnt >= tpoll);
    end

    // Request classes and winner
    always_comb begin
        data_req = link_active & txdat_ready & dec_flow & LINK_MASK;
        poll_req = link_active & tpoll_expired & LINK_MASK;
`ifdef SCHED_ARQ_PRIO_EN
        owe_req  = link_active & arq_owed & ~data_req & LINK_MASK;
`else
        owe_req  = '0;
`endif
        data_pick = rr_pick(data_req, rr_ptr);
        owe_pick  = rr_pick(owe_req, rr_ptr);
        poll_pick = rr_pick(poll_req, rr_ptr);

        win_hit  = 1'b0;
        win_addr = '0;
        win_kind = K_NONE;
        if (data_pick[3]) begin
            win_hit  = 1'b1;
            win_addr = data_pick[2:0];
            win_kind = K_DATA;
        end else if (owe_pick[3]) begin
            win_hit  = 1'b1;
            win_addr = owe_pick[2:0];
            win_kind = K_NACK;
        end else if (poll_pick[3]) begin
            win_hit  = 1'b1;
            win_addr = poll_pick[2:0];
            win_kind = K_POLL;
        end
    end

`ifndef SCHED_ARQ_PRIO_EN
    logic unused_arq;
    assign unused_arq = ^arq_owed;
`endif

    // Next-state and registered-output logic
    always_comb begin
        state_nx   = state;
        rr_ptr_nx  = rr_ptr;
        valid_nx   = sched_valid;
        addr_nx    = sched_lt_addr;
        kind_nx    = sched_kind;
        grant_ld   = 1'b0;
        overrun_nx = ms_tslot_p && (state != IDLE);

        if (!run && state != IDLE) begin
            state_nx = IDLE;
            valid_nx = 1'b0;
            kind_nx  = K_NONE;
        end else begin
            case (state)
                IDLE: begin
                    if (ms_tslot_p && run && !sco_reserved)
                        state_nx = ARB;
                end
                ARB: begin
                    state_nx = IDLE;
                    if (win_hit) begin
                        state_nx  = GRANT;
                        valid_nx  = 1'b1;
                        addr_nx   = win_addr;
                        kind_nx   = win_kind;
                        rr_ptr_nx = win_addr;
                        grant_ld  = 1'b1;
                    end
                end
                GRANT: begin
                    if (ms_TXslot_endp) begin
                        valid_nx = 1'b0;
                        kind_nx  = K_NONE;
                        state_nx = ms_RXslot_endp ? IDLE : WAIT_RX;
                    end
                end
                WAIT_RX: begin
                    if (ms_RXslot_endp)
                        state_nx = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_6M or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            sched_valid   <= 1'b0;
            sched_lt_addr <= '0;
            sched_kind    <= K_NONE;
            sched_overrun <= 1'b0;
        end else begin
            state         <= state_nx;
            rr_ptr        <= rr_ptr_nx;
            sched_valid   <= valid_nx;
            sched_lt_addr <= addr_nx;
            sched_kind    <= kind_nx;
            sched_overrun <= overrun_nx;
        end
    end

endmodule

// File: tb/tb_acl_poll_sched.sv
// tb_acl_poll_sched: directed scoreboard bench for acl_poll_sched.
// Expected grants are queued at stimulus time and popped on sched_valid.

module tb_acl_poll_sched;

    localparam int CNT_W = 16;

    logic             clk_6M = 1'b0;
    logic             rst;
    logic             sched_en;
    logic             regi_isMaster;
    logic [7:0]       link_active;
    logic [7:0]       txdat_ready;
    logic [7:0]       dec_flow;
    logic [7:0]       arq_owed;
    logic             tpoll_wr;
    logic [CNT_W-1:0] tpoll_wdata;
    logic             sco_reserved;
    logic             ms_tslot_p;
    logic             ms_TXslot_endp;
    logic             ms_RXslot_endp;
    logic             sched_valid;
    logic [2:0]       sched_lt_addr;
    logic [1:0]       sched_kind;
    logic             sched_busy;
    logic             sched_overrun;
    logic [7:0]       tpoll_expired;

    acl_poll_sched #(.CNT_W(CNT_W), .TPOLL_RST(40)) dut (
        .clk_6M         (clk_6M),
        .rst            (rst),
        .sched_en       (sched_en),
        .regi_isMaster  (regi_isMaster),
        .link_active    (link_active),
        .txdat_ready    (txdat_ready),
        .dec_flow       (dec_flow),
        .arq_owed       (arq_owed),
        .tpoll_wr       (tpoll_wr),
        .tpoll_wdata    (tpoll_wdata),
        .sco_reserved   (sco_reserved),
        .ms_tslot_p     (ms_tslot_p),
        .ms_TXslot_endp (ms_TXslot_endp),
        .ms_RXslot_endp (ms_RXslot_endp),
        .sched_valid    (sched_valid),
        .sched_lt_addr  (sched_lt_addr),
        .sched_kind     (sched_kind),
        .sched_busy     (sched_busy),
        .sched_overrun  (sched_overrun),
        .tpoll_expired  (tpoll_expired)
    );

    always #5 clk_6M = ~clk_6M;

    typedef struct packed {
        logic [2:0] addr;
        logic [1:0] kind;
    } exp_t;

    exp_t sbq[$];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_6M);
    endtask

    task automatic pulse_tslot();
        @(negedge clk_6M) ms_tslot_p = 1'b1;
        @(negedge clk_6M) ms_tslot_p = 1'b0;
    endtask

    task automatic pulse_tx();
        @(negedge clk_6M) ms_TXslot_endp = 1'b1;
        @(negedge clk_6M) ms_TXslot_endp = 1'b0;
    endtask

    task automatic pulse_rx();
        @(negedge clk_6M) ms_RXslot_endp = 1'b1;
        @(negedge clk_6M) ms_RXslot_endp = 1'b0;
    endtask

    task automatic write_tpoll(input logic [CNT_W-1:0] v);
        @(negedge clk_6M) begin
            tpoll_wr    = 1'b1;
            tpoll_wdata = v;
        end
        @(negedge clk_6M) tpoll_wr = 1'b0;
    endtask

    // Start a slot pair and compare the grant against the scoreboard
    task automatic slot_grant(input string tag);
        exp_t e;
        int   n;
        pulse_tslot();
        n = 0;
        while (sched_valid !== 1'b1 && n < 6) begin
            @(negedge clk_6M);
            n++;
        end
        chk({tag, "_lat"}, n, 1);
        chk({tag, "_sbq"}, sbq.size(), 1);
        if (sbq.size() != 0) begin
            e = sbq.pop_front();
            chk({tag, "_addr"}, sched_lt_addr, e.addr);
            chk({tag, "_kind"}, sched_kind, e.kind);
        end
    endtask

    task automatic slot_end(input string tag);
        pulse_tx();
        chk({tag, "_txv"}, sched_valid, 0);
        chk({tag, "_txk"}, sched_kind, 0);
        chk({tag, "_txb"}, sched_busy, 1);
        pulse_rx();
        chk({tag, "_rxb"}, sched_busy, 0);
    endtask

    initial begin
        rst            = 1'b1;
        sched_en       = 1'b0;
        regi_isMaster  = 1'b0;
        link_active    = '0;
        txdat_ready    = '0;
        dec_flow       = '0;
        arq_owed       = '0;
        tpoll_wr       = 1'b0;
        tpoll_wdata    = '0;
        sco_reserved   = 1'b0;
        ms_tslot_p     = 1'b0;
        ms_TXslot_endp = 1'b0;
        ms_RXslot_endp = 1'b0;

        // Reset state
        cyc(3);
        chk("rst_valid", sched_valid, 0);
        chk("rst_addr", sched_lt_addr, 0);
        chk("rst_kind", sched_kind, 0);
        chk("rst_busy", sched_busy, 0);
        chk("rst_ovr", sched_overrun, 0);
        chk("rst_exp", tpoll_expired, 0);
        rst = 1'b0;
        cyc(2);

        // Data round-robin on 1,3,5 (bit0 requests ignored)
        sched_en      = 1'b1;
        regi_isMaster = 1'b1;
        link_active   = 8'b0010_1011;
        txdat_ready   = 8'b0010_1011;
        dec_flow      = 8'hFF;
        sbq.push_back(exp_t'{3'd1, 2'b01});
        slot_grant("d1");
        txdat_ready = 8'h00;
        dec_flow    = 8'h00;
        cyc(2);
        chk("d1_hold_v", sched_valid, 1);
        chk("d1_hold_a", sched_lt_addr, 1);
        chk("d1_hold_k", sched_kind, 2'b01);
        txdat_ready = 8'b0010_1011;
        dec_flow    = 8'hFF;
        slot_end("d1");
        sbq.push_back(exp_t'{3'd3, 2'b01});
        slot_grant("d3");
        slot_end("d3");
        sbq.push_back(exp_t'{3'd5, 2'b01});
        slot_grant("d5");
        slot_end("d5");
        sbq.push_back(exp_t'{3'd1, 2'b01});
        slot_grant("d1b");
        slot_end("d1b");

        // Tpoll expiry on link 2, aged through SCO-reserved slot pairs
        link_active = 8'b0000_0100;
        txdat_ready = 8'h00;
        write_tpoll(16'd4);
        sco_reserved = 1'b1;
        pulse_tslot();
        pulse_tslot();
        pulse_tslot();
        chk("p2_exp3", tpoll_expired, 8'h00);
        pulse_tslot();
        chk("p2_exp4", tpoll_expired, 8'h04);
        chk("p2_sco_busy", sched_busy, 0);
        sco_reserved = 1'b0;
        sbq.push_back(exp_t'{3'd2, 2'b10});
        slot_grant("p2");
        chk("p2_clr", tpoll_expired, 8'h00);
        slot_end("p2");

        // Flow STOP and polling disabled: no grant
        link_active = 8'b0001_0000;
        txdat_ready = 8'b0001_0000;
        dec_flow    = 8'b1110_1111;
        write_tpoll(16'd0);
        pulse_tslot();
        chk("f4_arb", sched_busy, 1);
        cyc(1);
        chk("f4_idle", sched_busy, 0);
        chk("f4_v0", sched_valid, 0);
        cyc(3);
        chk("f4_v1", sched_valid, 0);
        chk("f4_exp", tpoll_expired, 8'h00);

        // Overrun: slot pair start during GRANT
        link_active = 8'b0000_1000;
        txdat_ready = 8'b0000_1000;
        dec_flow    = 8'hFF;
        sbq.push_back(exp_t'{3'd3, 2'b01});
        slot_grant("o3");
        pulse_tslot();
        chk("o3_ovr", sched_overrun, 1);
        chk("o3_addr", sched_lt_addr, 3);
        chk("o3_v", sched_valid, 1);
        cyc(1);
        chk("o3_ovr0", sched_overrun, 0);
        slot_end("o3");

        // sched_en drop during GRANT, then resume after last grant
        link_active = 8'b0110_1000;
        txdat_ready = 8'b0110_1000;
        sbq.push_back(exp_t'{3'd5, 2'b01});
        slot_grant("e5");
        sched_en = 1'b0;
        cyc(1);
        chk("e5_v", sched_valid, 0);
        chk("e5_b", sched_busy, 0);
        chk("e5_k", sched_kind, 0);
        sched_en = 1'b1;
        sbq.push_back(exp_t'{3'd6, 2'b01});
        slot_grant("e6");
        slot_end("e6");

        // Owed ACK on link 6 versus poll-expired link 1
        link_active = 8'b0000_0010;
        txdat_ready = 8'h00;
        write_tpoll(16'd2);
        sco_reserved = 1'b1;
        pulse_tslot();
        pulse_tslot();
        sco_reserved = 1'b0;
        chk("a_exp", tpoll_expired, 8'h02);
        link_active = 8'b0100_0010;
        arq_owed    = 8'b0100_0000;
`ifdef SCHED_ARQ_PRIO_EN
        sbq.push_back(exp_t'{3'd6, 2'b11});
`else
        sbq.push_back(exp_t'{3'd1, 2'b10});
`endif
        slot_grant("a");
        slot_end("a");

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
